// File: rtl/xor_pkg.sv
// Shared types and helpers for the streaming XOR checksum unit.
package xor_pkg;

  // Frame-level control states.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAccum = 2'd1,
    StDone  = 2'd2
  } state_e;

  // Ceiling log2, used to size the frame-length counter.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned v;
    result = 0;
    v      = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return (result == 0) ? 1 : result;
  endfunction

endpackage

// File: rtl/xor_word.sv
// Combinational bitwise XOR of two WIDTH-bit words.
module xor_word #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] y_o
);

  assign y_o = a_i ^ b_i;

endmodule

// File: rtl/xor_accum.sv
// Streaming XOR checksum: folds a frame of words into one XOR sum, reports
// the frame length (saturating at MAX_LEN) and an overflow flag, and holds
// the result until the sink takes it.
// Optional feature: define XOR_PARITY_OUT_EN to add the out_parity port.
module xor_accum
  import xor_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned MAX_LEN = 16,
  localparam int unsigned CNT_W  = clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [CNT_W-1:0] out_len,
`ifdef XOR_PARITY_OUT_EN
  output logic             out_err,
  output logic             out_parity
`else
  output logic             out_err
`endif
);

  localparam logic [CNT_W-1:0] LenMax = CNT_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] LenOne = CNT_W'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] acc_xor;
  logic             in_xfer;
  logic             out_xfer;
  logic             len_at_max;

  assign in_xfer    = in_valid & in_ready;
  assign out_xfer   = out_valid & out_ready;
  assign len_at_max = (len_q == LenMax);

  xor_word #(
    .WIDTH(WIDTH)
  ) u_xor_word (
    .a_i(acc_q),
    .b_i(in_data),
    .y_o(acc_xor)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: collect beats until in_last, then hold until consumed.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StAccum: begin
        if (in_xfer) begin
          state_d = in_last ? StDone : StAccum;
        end
      end
      StDone: begin
        if (out_xfer) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Handshake outputs decoded from the registered state only (glitch-free).
  always_comb begin
    in_ready  = (state_q != StDone);
    out_valid = (state_q == StDone);
  end

  // Datapath next-state: first beat loads, later beats fold in and count.
  always_comb begin
    acc_d = acc_q;
    len_d = len_q;
    err_d = err_q;
    if (in_xfer) begin
      if (state_q == StIdle) begin
        acc_d = in_data;
        len_d = LenOne;
        err_d = 1'b0;
      end else begin
        // Overflow beats still contribute to the sum.
        acc_d = acc_xor;
        len_d = len_at_max ? LenMax : len_q + LenOne;
        err_d = err_q | len_at_max;
      end
    end
  end

  // Datapath registers; reset discards any partial frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      len_q <= '0;
      err_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      len_q <= len_d;
      err_q <= err_d;
    end
  end

  assign out_sum = acc_q;
  assign out_len = len_q;
  assign out_err = err_q;

`ifdef XOR_PARITY_OUT_EN
  logic parity_q;

  // Parity tracks the accumulator so it is valid alongside out_sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= ^acc_d;
    end
  end

  assign out_parity = parity_q;
`endif

endmodule

// File: tb/tb_xor_accum.sv
// Scoreboard bench for xor_accum (WIDTH=8, MAX_LEN=4). Expected results are
// queued when a frame is issued; a monitor pops and compares on each output
// transfer.
module tb_xor_accum;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned MAX_LEN = 4;
  localparam int unsigned CNT_W   = 3;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic [CNT_W-1:0] len;
    logic             err;
    logic             par;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic [CNT_W-1:0] out_len;
  logic             out_err;
`ifdef XOR_PARITY_OUT_EN
  logic             out_parity;
`endif

  int   checks;
  int   failures;
  exp_t exp_q[$];

  xor_accum #(
    .WIDTH  (WIDTH),
    .MAX_LEN(MAX_LEN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_len   (out_len),
`ifdef XOR_PARITY_OUT_EN
    .out_err   (out_err),
    .out_parity(out_parity)
`else
    .out_err   (out_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Monitor: an output transfer happens at the next rising edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output actual=0x%0h required=none", out_sum);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_sum", 32'(out_sum), 32'(e.sum));
        chk("out_len", 32'(out_len), 32'(e.len));
        chk("out_err", 32'(out_err), 32'(e.err));
`ifdef XOR_PARITY_OUT_EN
        chk("out_parity", 32'(out_parity), 32'(e.par));
`endif
      end
    end
  end

  // Present one beat and return #1 after the edge that accepted it.
  task automatic send(input logic [WIDTH-1:0] data, input logic last);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_data  = data;
    in_last  = last;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 50) begin
        checks++;
        failures++;
        $display("FAIL send_timeout actual=in_ready_low required=in_ready_high");
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 'x;
    in_last  = 1'b0;
  endtask

  task automatic expect_frame(input logic [WIDTH-1:0] sum, input logic [CNT_W-1:0] len,
                              input logic err, input logic par);
    exp_t e;
    e.sum = sum;
    e.len = len;
    e.err = err;
    e.par = par;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;

    // 1: reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sum", 32'(out_sum), 32'd0);
    chk("rst_out_len", 32'(out_len), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
`ifdef XOR_PARITY_OUT_EN
    chk("rst_out_parity", 32'(out_parity), 32'd0);
`endif
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 2: three-beat frame, result one cycle after last beat
    expect_frame(8'h55, 3'd3, 1'b0, 1'b0);
    send(8'h0F, 1'b0);
    send(8'hF0, 1'b0);
    send(8'hAA, 1'b1);
    chk("lat_out_valid", 32'(out_valid), 32'd1);
    chk("lat_in_ready", 32'(in_ready), 32'd0);
    drain();

    // 3: single beat with the sink stalled for 5 cycles
    out_ready = 1'b0;
    expect_frame(8'h3C, 3'd1, 1'b0, 1'b0);
    send(8'h3C, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_out_sum", 32'(out_sum), 32'h3C);
      chk("stall_out_len", 32'(out_len), 32'd1);
    end
    out_ready = 1'b1;
    drain();
    chk("post_xfer_out_valid", 32'(out_valid), 32'd0);
    chk("post_xfer_in_ready", 32'(in_ready), 32'd1);

    // 4: six beats overflow MAX_LEN=4
    expect_frame(8'h07, 3'd4, 1'b1, 1'b1);
    for (int i = 1; i <= 6; i++) begin
      send(8'(i), (i == 6));
    end
    drain();

    // 5: reset mid-frame discards the partial frame
    send(8'h21, 1'b0);
    send(8'h42, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_out_len", 32'(out_len), 32'd0);
    chk("abort_out_sum", 32'(out_sum), 32'd0);
    expect_frame(8'h11, 3'd1, 1'b0, 1'b0);
    send(8'h11, 1'b1);
    drain();

    // 6: parity cases (sum and length checked in every build)
    expect_frame(8'h07, 3'd1, 1'b0, 1'b1);
    send(8'h07, 1'b1);
    drain();
    expect_frame(8'h03, 3'd1, 1'b0, 1'b0);
    send(8'h03, 1'b1);
    drain();

    repeat (3) @(posedge clk);
    #1;
    chk("idle_out_valid", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
